// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the instruction-fetch / LSU data-memory port arbiter.
// Requester IDs double as the response-routing tag stored in the ID FIFO.
package mem_arb_pkg;

  typedef enum logic {FREE = 1'b0, LOCK = 1'b1} arb_st_e;

  typedef logic req_id_t;

  localparam req_id_t ID_IFU = 1'b0;
  localparam req_id_t ID_LSU = 1'b1;

  localparam logic [3:0] BMSK_FULL = 4'hF;

  // Non-address part of a downstream request; address width is a top-level parameter.
  typedef struct packed {
    logic [3:0]  bmsk;
    logic        wren;
    logic [31:0] data;
  } mem_pld_t;

  localparam mem_pld_t PLD_IFU = '{bmsk: BMSK_FULL, wren: 1'b0, data: 32'h0};

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order owner-ID FIFO; a push into a full FIFO is taken when the head
// leaves in the same cycle.
module arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    i_clk,
  input  logic    i_rstn,
  input  logic    i_push,
  input  req_id_t i_din,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output req_id_t o_head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_head  = mem[rd_ptr];

  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= ID_IFU;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin, grant-locking arbiter sharing one data-memory port between
// instruction fetch (r0, read-only) and the LSU (r1); responses routed in order.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  // requester 0 (instruction fetch)
  input  logic          i_r0_valid,
  output logic          o_r0_ready,
  input  logic [AW-1:0] i_r0_addr,
  output logic          o_r0_rvalid,
  input  logic          i_r0_rready,
  output logic [31:0]   o_r0_rdata,
  // requester 1 (load/store unit)
  input  logic          i_r1_valid,
  output logic          o_r1_ready,
  input  logic [AW-1:0] i_r1_addr,
  input  logic [3:0]    i_r1_bmsk,
  input  logic          i_r1_wren,
  input  logic [31:0]   i_r1_wdata,
  output logic          o_r1_rvalid,
  input  logic          i_r1_rready,
  output logic [31:0]   o_r1_rdata,
  // downstream request
  output logic          o_m_valid,
  input  logic          i_m_ready,
  output logic [AW-1:0] o_m_addr,
  output logic [3:0]    o_m_bmsk,
  output logic          o_m_wren,
  output logic [31:0]   o_m_data,
  // downstream response
  input  logic          i_m_valid,
  output logic          o_m_ready,
  input  logic [31:0]   i_m_data,
  output logic          o_err
);

  arb_st_e  st_q, st_d;
  req_id_t  owner_q, owner_d;
  req_id_t  last_q, last_d;
  req_id_t  win_id;
  logic     win_vld;
  logic     accept, can_push;
  logic     fifo_full, fifo_empty, fifo_pop;
  req_id_t  fifo_head;
  logic     head_rready, rsp_live;
  mem_pld_t r1_pld, win_pld;

  assign r1_pld = '{bmsk: i_r1_bmsk, wren: i_r1_wren, data: i_r1_wdata};

  // Winner select; a locked owner is presented no matter what the other side does.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ID_IFU;
    if (st_q == LOCK) begin
      win_id  = owner_q;
      win_vld = (owner_q == ID_LSU) ? i_r1_valid : i_r0_valid;
    end else if (i_r0_valid && i_r1_valid) begin
      win_vld = 1'b1;
      win_id  = ~last_q;
    end else if (i_r0_valid) begin
      win_vld = 1'b1;
      win_id  = ID_IFU;
    end else if (i_r1_valid) begin
      win_vld = 1'b1;
      win_id  = ID_LSU;
    end
    win_vld = win_vld & i_rstn;
  end

  // Response side: the FIFO head decides which requester sees the response.
  assign head_rready = (fifo_head == ID_LSU) ? i_r1_rready : i_r0_rready;
  assign o_m_ready   = head_rready & ~fifo_empty;
  assign fifo_pop    = i_m_valid & o_m_ready;
  assign rsp_live    = i_m_valid & ~fifo_empty;

  assign o_r0_rvalid = rsp_live & (fifo_head == ID_IFU);
  assign o_r1_rvalid = rsp_live & (fifo_head == ID_LSU);
  assign o_r0_rdata  = o_r0_rvalid ? i_m_data : 32'h0;
  assign o_r1_rdata  = o_r1_rvalid ? i_m_data : 32'h0;

  // Request side: a full FIFO only frees a slot if the head retires this cycle.
  assign can_push   = ~fifo_full | fifo_pop;
  assign o_m_valid  = win_vld & can_push;
  assign accept     = o_m_valid & i_m_ready;
  assign o_r0_ready = accept & (win_id == ID_IFU);
  assign o_r1_ready = accept & (win_id == ID_LSU);

  always_comb begin
    win_pld  = '0;
    o_m_addr = '0;
    if (win_vld) begin
      win_pld  = (win_id == ID_LSU) ? r1_pld : PLD_IFU;
      o_m_addr = (win_id == ID_LSU) ? i_r1_addr : i_r0_addr;
    end
  end

  assign o_m_bmsk = win_pld.bmsk;
  assign o_m_wren = win_pld.wren;
  assign o_m_data = win_pld.data;

  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (win_vld) begin
      if (accept) begin
        st_d   = FREE;
        last_d = win_id;
      end else begin
        st_d    = LOCK;
        owner_d = win_id;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      st_q    <= FREE;
      owner_q <= ID_IFU;
      last_q  <= ID_LSU;
      o_err   <= 1'b0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (i_m_valid && fifo_empty) o_err <= 1'b1;
    end
  end

  arb_id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (accept),
    .i_din   (win_id),
    .i_pop   (fifo_pop),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_head  (fifo_head)
  );

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-requester arbiter that shares the single data-memory request/response port between instruction fetch (requester 0, read-only) and the load/store unit (requester 1, read/write). It sits between the core front-end/LSU and the data-memory/cache block. Request channels are arbitrated round-robin with grant locking. Every accepted request produces exactly one downstream response, which is routed back to its owner through an in-order ID FIFO.

## Interface
- DEPTH, 2: maximum outstanding accepted-but-unanswered requests (ID FIFO depth, ≥1)
- AW, 32: address width
- i_clk  in  1  clock, all state on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_r0_valid / o_r0_ready  in/out  1  requester 0 request handshake
- i_r0_addr  in  AW  requester 0 byte address (read, bmsk forced 4'hF)
- o_r0_rvalid / i_r0_rready  out/in  1  requester 0 response handshake
- o_r0_rdata  out  32  requester 0 read data
- i_r1_valid / o_r1_ready  in/out  1  requester 1 request handshake
- i_r1_addr  in  AW; i_r1_bmsk  in  4; i_r1_wren  in  1; i_r1_wdata  in  32  requester 1 request payload
- o_r1_rvalid / i_r1_rready  out/in  1  requester 1 response handshake
- o_r1_rdata  out  32  requester 1 read data (also returned for writes)
- o_m_valid / i_m_ready  out/in  1  downstream request handshake
- o_m_addr AW, o_m_bmsk 4, o_m_wren 1, o_m_data 32  out  downstream payload
- i_m_valid / o_m_ready  in/out  1  downstream response handshake
- i_m_data  in  32  downstream response data
- o_err  out  1  sticky: downstream response seen with ID FIFO empty

## Operation
- Arbiter FSM: FREE, LOCK. State register owner (1 bit), last_winner (1 bit, reset 1 so requester 0 wins first).
- FREE: if exactly one requester is valid, it wins. If both are valid, the requester other than last_winner wins.
- Winner is driven onto o_m_* combinationally. For requester 0: o_m_wren=0, o_m_bmsk=4'hF, o_m_data=0.
- When no winner exists, o_m_valid=0 and all o_m_* payload is 0.
- Winner presented and not accepted (i_m_ready=0, or FIFO full) → LOCK with owner=winner. Requesters must hold valid and payload stable while unaccepted.
- LOCK: only the owner is presented, regardless of the other requester's valid. Acceptance returns the FSM to FREE.
- Accept condition: o_m_valid & i_m_ready & fifo_can_push. fifo_can_push = !full | pop_this_cycle.
- On accept: push winner ID, last_winner ← winner, o_rX_ready=1 for the winner only.
- FIFO full with no pop: o_m_valid=0, o_r0_ready=o_r1_ready=0, and the FSM holds LOCK if already locked.
- Response path, head ID h: o_rh_rvalid=i_m_valid, o_rh_rdata=i_m_data, o_m_ready=i_rh_rready & !empty.
- Non-head response outputs: rvalid=0, rdata=0.
- Pop on i_m_valid & o_m_ready.
- Responses return strictly in acceptance order.
- i_m_valid with FIFO empty: o_m_ready=0, o_err set until reset.

## Timing
- Request pass-through: 0 cycles, combinational from i_rX_* to o_m_*.
- Response pass-through: 0 cycles, combinational.
- Same-cycle push and pop permitted at any occupancy, including full and empty.
- Reset values: FSM=FREE, FIFO empty (count 0), last_winner=1, o_err=0.
- All ready/valid outputs are 0 during reset, and all payload outputs are 0.
- Reset mid-operation: outstanding IDs and lock are discarded immediately (asynchronous). Downstream shares i_rstn and is reset with the arbiter.
- FIFO count width is clog2(DEPTH+1). Read and write pointers wrap modulo DEPTH.
- Sustained throughput: one request per cycle while downstream accepts and responses drain.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum logic {FREE, LOCK} arb_st_e
  - typedef logic req_id_t
  - localparams ID_IFU=1'b0, ID_LSU=1'b1
- Sub-module arb_id_fifo: synchronous FIFO, width 1, depth DEPTH, async active-low reset. Provides push/pop/full/empty/head and permits simultaneous push+pop when full.
- The top level holds the FSM, the request mux and the response demux.

## Test plan
- Single read: r0 valid, addr 0x100, downstream ready → o_m_addr=0x100, wren=0, bmsk=F same cycle. Response 0xDEADBEEF reaches o_r0_rdata only; o_r1_rvalid stays 0.
- Contention: both valid for 4 consecutive accepts → grants r0, r1, r0, r1. last_winner=1 after the 4th.
- Lock: r1 write addr 0x40, bmsk 4'h3, i_m_ready=0 for 3 cycles while r0 is asserted → r1 payload held on o_m_*, r0 not granted. r1 is accepted on cycle 4.
- Full FIFO, DEPTH=2: two accepts with no response → o_m_valid=0 and both readies 0. A response with head rready=1 lets a third request be accepted in the same cycle.
- Backpressure: head owner r1 with i_r1_rready=0 → o_m_ready=0 until rready rises. Responses then arrive in order r1, r0.
- Reset mid-flight: assert i_rstn low with 2 outstanding → all outputs 0, FIFO empty. A stray i_m_valid after reset sets o_err=1.
